stack_ctrl: RTL and testbench

LIFO controller that sits directly upstream of the stack register file. It turns push/pop requests into the file's write-enable and write/read addresses, and forwards push data as the file's write data. It also captures the file's combinational read data into a registered pop output. It tracks occupancy, full/empty status and sticky overflow/underflow errors.

---
 rtl/stack_ctrl.sv | 110 +++++++++++
 tb/tb_stack_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// ---------------------------------------------------------------------------
// stack_ctrl : LIFO controller driving an external asynchronous-read register
//              file; tracks occupancy and sticky overflow/underflow errors.
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stack_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  clear_err,
  output logic                  rf_wr_en,
  output logic [ADDR_WIDTH-1:0] rf_w_addr,
  output logic [ADDR_WIDTH-1:0] rf_r_addr,
  output logic [DATA_WIDTH-1:0] rf_w_data,
  input  logic [DATA_WIDTH-1:0] rf_r_data,
  output logic [DATA_WIDTH-1:0] top_data,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] c_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] c_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_pop_data;
  logic                  r_pop_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_empty;
  logic                  w_full;
  logic [ADDR_WIDTH:0]   w_count_m1;
  logic                  w_push_ok;
  logic                  w_replace;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_DEPTH);
  assign w_count_m1 = r_count - c_ONE;

  // Write only when the push is actually accepted: plain push with room, or
  // replace-top on a non-empty stack. Bypass and dropped pushes never write.
  assign w_push_ok  = push & ~pop & ~w_full;
  assign w_replace  = push & pop & ~w_empty;

  assign rf_wr_en   = w_push_ok | w_replace;
  assign rf_r_addr  = w_count_m1[ADDR_WIDTH-1:0];
  assign rf_w_addr  = pop ? w_count_m1[ADDR_WIDTH-1:0] : r_count[ADDR_WIDTH-1:0];
  assign rf_w_data  = push_data;
  assign top_data   = rf_r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_pop_valid <= 1'b0;
      // Clear first so an error in the same cycle wins.
      if (clear_err) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end
      case ({push, pop})
        2'b10: begin
          if (w_full) r_overflow <= 1'b1;
          else        r_count    <= r_count + c_ONE;
        end
        2'b01: begin
          if (w_empty) begin
            r_underflow <= 1'b1;
          end else begin
            r_pop_data  <= rf_r_data;
            r_pop_valid <= 1'b1;
            r_count     <= w_count_m1;
          end
        end
        2'b11: begin
          r_pop_valid <= 1'b1;
          r_pop_data  <= w_empty ? push_data : rf_r_data;
        end
        default: ;
      endcase
    end
  end

  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign pop_data  = r_pop_data;
  assign pop_valid = r_pop_valid;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_stack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stack_ctrl : directed bench with a pop-data scoreboard and a behavioural
//                 register file hanging off the controller.
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_stack_ctrl;

  localparam int AW = 2;
  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          push = 1'b0, pop = 1'b0, clear_err = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          rf_wr_en;
  logic [AW-1:0] rf_w_addr, rf_r_addr;
  logic [DW-1:0] rf_w_data, rf_r_data, top_data, pop_data;
  logic          pop_valid, empty, full, overflow, underflow;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem[4];

  always #5 clk = ~clk;

  stack_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .push_data(push_data),
    .clear_err(clear_err), .rf_wr_en(rf_wr_en), .rf_w_addr(rf_w_addr),
    .rf_r_addr(rf_r_addr), .rf_w_data(rf_w_data), .rf_r_data(rf_r_data),
    .top_data(top_data), .pop_data(pop_data), .pop_valid(pop_valid),
    .count(count), .empty(empty), .full(full), .overflow(overflow),
    .underflow(underflow)
  );

  always @(posedge clk) if (rf_wr_en) mem[rf_w_addr] <= rf_w_data;
  assign rf_r_data = mem[rf_r_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every pop_valid pulse must match the oldest expected pop word.
  always @(negedge clk) begin
    if (pop_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got pop_valid=1 data=%0d expected no pop at %0t", pop_data, $time);
      end else begin
        chk("pop_data", pop_data, exp_q.pop_front());
      end
    end
  end

  // Drive one cycle of stimulus; checks write-side decode before the edge.
  task automatic op(input logic p, input logic q, input logic [DW-1:0] d, input logic c,
                    input logic exp_we, input logic [AW-1:0] exp_wa,
                    input logic exp_pv, input logic [DW-1:0] exp_pd);
    push = p; pop = q; push_data = d; clear_err = c;
    #1;
    chk("rf_wr_en", rf_wr_en, exp_we);
    if (exp_we) chk("rf_w_addr", rf_w_addr, exp_wa);
    if (exp_pv) exp_q.push_back(exp_pd);
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; clear_err = 1'b0;
  endtask

  task automatic do_push(input logic [DW-1:0] d, input logic [AW-1:0] wa);
    op(1, 0, d, 0, 1, wa, 0, 0);
  endtask

  task automatic do_pop(input logic [DW-1:0] exp);
    op(0, 1, 0, 0, 0, 0, 1, exp);
  endtask

  task automatic clr();
    op(0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_pop_data", pop_data, 0);
    chk("rst_flags", {overflow, underflow}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic LIFO ordering
    do_push(1, 0); do_push(2, 1); do_push(3, 2);
    chk("count3", count, 3);
    chk("top3", top_data, 3);
    do_pop(3); do_pop(2); do_pop(1);
    chk("count_after_pops", count, 0);
    chk("empty_after_pops", empty, 1);

    // Fill and overflow
    do_push(0, 0); do_push(1, 1); do_push(2, 2); do_push(3, 3);
    chk("full", full, 1);
    chk("count4", count, 4);
    op(1, 0, 2, 0, 0, 0, 0, 0);
    chk("overflow_set", overflow, 1);
    chk("count_ovf", count, 4);
    chk("top_ovf", top_data, 3);
    clr();
    chk("overflow_clr", overflow, 0);

    // Replace top while full: no overflow
    op(1, 1, 1, 0, 1, 3, 1, 3);
    chk("count_repl_full", count, 4);
    chk("top_repl_full", top_data, 1);
    chk("no_ovf_repl", overflow, 0);
    do_pop(1); do_pop(2); do_pop(1); do_pop(0);
    chk("empty_drained", empty, 1);

    // Underflow and sticky clear
    op(0, 1, 0, 0, 0, 0, 0, 0);
    chk("underflow_set", underflow, 1);
    chk("pop_data_hold", pop_data, 0);
    chk("count_udf", count, 0);
    clr();
    chk("underflow_clr", underflow, 0);
    op(0, 1, 0, 1, 0, 0, 0, 0);
    chk("underflow_clr_and_set", underflow, 1);
    clr();

    // Replace top on partial stack
    do_push(1, 0); do_push(2, 1);
    op(1, 1, 3, 0, 1, 1, 1, 2);
    chk("count_repl", count, 2);
    chk("top_repl", top_data, 3);
    do_pop(3); do_pop(1);

    // Bypass on empty
    op(1, 1, 3, 0, 0, 0, 1, 3);
    chk("count_bypass", count, 0);
    chk("flags_bypass", {overflow, underflow}, 0);

    // Async reset during an in-flight pop
    op(0, 1, 0, 0, 0, 0, 0, 0);
    do_push(1, 0); do_push(2, 1); do_push(3, 2);
    pop = 1'b1;
    @(posedge clk); #1;
    pop = 1'b0;
    chk("pv_before_rst", pop_valid, 1);
    chk("pd_before_rst", pop_data, 3);
    rst_n = 1'b0;
    #1;
    chk("async_pv", pop_valid, 0);
    chk("async_count", count, 0);
    chk("async_udf", underflow, 0);
    chk("async_pd", pop_data, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("empty_after_rst", empty, 1);
    do_push(2, 0);
    chk("top_after_rst", top_data, 2);
    do_pop(2);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
